// File: rtl/puf_majority_voter.sv
// Majority voter over repeated PUF evaluations of one challenge.
// Produces a per-bit majority response and a per-bit unanimity mask, with a watchdog on the PUF.
module puf_majority_voter #(
  parameter int IN_WIDTH    = 128,
  parameter int OUT_WIDTH   = 16,
  parameter int NUM_SAMPLES = 15,
  parameter int TIMEOUT     = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [IN_WIDTH-1:0]  challengeIn,
  output logic                 pufTrigger,
  output logic [IN_WIDTH-1:0]  pufChallenge,
  input  logic                 pufDone,
  input  logic [OUT_WIDTH-1:0] pufResponse,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [OUT_WIDTH-1:0] responseOut,
  output logic [OUT_WIDTH-1:0] stableMask
);

  // Handshake: start is a request taken only in IDLE (ignored otherwise); pufTrigger is a
  // one-cycle request to the PUF, answered by a one-cycle pufDone with pufResponse valid
  // alongside it. There is no backpressure; pufDone outside WAIT is dropped.
  typedef enum logic [1:0] {IDLE, TRIG, WAIT, FINISH} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_SAMPLES - 1);
  localparam logic [4:0] HALF     = 5'(NUM_SAMPLES / 2);
  localparam logic [4:0] FULL     = 5'(NUM_SAMPLES);
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);

  state_t                r_state, w_next;
  logic [4:0]            r_idx;
  logic [7:0]            r_wd;
  logic [4:0]            r_cnt [OUT_WIDTH];
  logic [4:0]            w_cnt_next [OUT_WIDTH];
  logic [OUT_WIDTH-1:0]  w_resp, w_stable;
  logic                  w_sample, w_timeout;
  logic                  r_trig, r_busy, r_done, r_error;
  logic [IN_WIDTH-1:0]   r_chal;
  logic [OUT_WIDTH-1:0]  r_resp, r_mask;

  assign w_sample  = (r_state == WAIT) && pufDone;
  assign w_timeout = (r_state == WAIT) && !pufDone && (r_wd == WD_LIMIT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = TRIG;
      TRIG:    w_next = WAIT;
      WAIT: begin
        if (pufDone)        w_next = (r_idx == LAST_IDX) ? FINISH : TRIG;
        else if (w_timeout) w_next = FINISH;
      end
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Results are taken from the post-update counters so they appear together with done.
  always_comb begin
    w_resp   = '0;
    w_stable = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      w_cnt_next[i] = w_sample ? r_cnt[i] + {4'b0, pufResponse[i]} : r_cnt[i];
      w_resp[i]     = (w_cnt_next[i] > HALF);
      w_stable[i]   = (w_cnt_next[i] == 5'd0) || (w_cnt_next[i] == FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_wd    <= '0;
      r_trig  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_chal  <= '0;
      r_resp  <= '0;
      r_mask  <= '0;
      for (int i = 0; i < OUT_WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_state <= w_next;
      r_trig  <= (w_next == TRIG);
      r_busy  <= (w_next != IDLE);
      r_done  <= (w_next == FINISH);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_chal  <= challengeIn;
            r_idx   <= '0;
            r_wd    <= '0;
            r_error <= 1'b0;
            for (int i = 0; i < OUT_WIDTH; i++) r_cnt[i] <= '0;
          end
        end
        TRIG: r_wd <= '0;
        WAIT: begin
          r_wd <= r_wd + 8'd1;
          if (w_sample) begin
            r_idx <= r_idx + 5'd1;
            for (int i = 0; i < OUT_WIDTH; i++) r_cnt[i] <= w_cnt_next[i];
            if (w_next == FINISH) begin
              r_resp <= w_resp;
              r_mask <= w_stable;
            end
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_resp  <= '0;
            r_mask  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign pufTrigger   = r_trig;
  assign pufChallenge = r_chal;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign responseOut  = r_resp;
  assign stableMask   = r_mask;

endmodule

// File: doc/puf_majority_voter.md
PUF_MAJORITY_VOTER -- requirements
Module: puf_majority_voter

Interface
REQ-001 Parameter IN_WIDTH, default 128, SHALL set the challenge width.
REQ-002 Parameter OUT_WIDTH, default 16, SHALL set the response width.
REQ-003 Parameter NUM_SAMPLES, default 15, SHALL set evaluations per vote; the legal range is odd values from 1 to 31.
REQ-004 Parameter TIMEOUT, default 255, SHALL set the maximum cycles to wait for pufDone; the legal range is 1 to 255.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have these ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  host request; one-cycle pulse or level, sampled only in IDLE
- challengeIn  in  IN_WIDTH  challenge to evaluate
- pufTrigger  out  1  trigger to the PUF mapping stage
- pufChallenge  out  IN_WIDTH  challenge presented to the mapping stage
- pufDone  in  1  one-cycle completion pulse from the mapping stage
- pufResponse  in  OUT_WIDTH  response from the mapping stage, valid with pufDone
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle result-valid pulse
- error  out  1  timeout flag, valid with done
- responseOut  out  OUT_WIDTH  majority-voted response
- stableMask  out  OUT_WIDTH  per-bit unanimity flag
REQ-007 All outputs SHALL be registered.

Function
REQ-008 The FSM SHALL have the states IDLE, TRIG, WAIT and FINISH.
REQ-009 In IDLE, start=1 SHALL do the following:
- latch challengeIn into pufChallenge;
- clear all per-bit counters, the sample index and the watchdog;
- clear error;
- go to TRIG.
REQ-010 In TRIG, pufTrigger SHALL be 1 for exactly one cycle, the watchdog SHALL be cleared, and the next state SHALL be WAIT.
REQ-011 In WAIT, pufTrigger SHALL be 0 and the watchdog SHALL increment each cycle.
REQ-012 In WAIT, pufDone=1 SHALL do the following:
- add pufResponse[i] to counter[i] for every bit i;
- increment the sample index;
- go to FINISH if the index was NUM_SAMPLES-1, else go to TRIG.
REQ-013 Per-bit counters SHALL be 5 bits wide and SHALL never wrap, because NUM_SAMPLES is at most 31.
REQ-014 If the watchdog reaches TIMEOUT in WAIT without pufDone, the block SHALL set error=1 and go to FINISH; samples already collected SHALL be discarded, and responseOut and stableMask SHALL be driven to 0.
REQ-015 If pufDone and the timeout occur in the same cycle, pufDone SHALL win and the sample SHALL be counted.
REQ-016 In FINISH without error, responseOut and stableMask SHALL be computed per bit i:
- responseOut[i] = 1 if counter[i] > NUM_SAMPLES/2 (integer division), else 0;
- stableMask[i] = 1 if counter[i] is 0 or NUM_SAMPLES.
REQ-017 In FINISH, done SHALL pulse high for one cycle and the next state SHALL be IDLE.
REQ-018 responseOut, stableMask and error SHALL hold their values until the next start.
REQ-019 start while busy=1 SHALL be ignored, and pufChallenge SHALL remain stable for the whole vote.
REQ-020 pufDone outside WAIT SHALL be ignored, with no counter change.
REQ-021 With the mapping stage's 16-cycle compute time, one sample SHALL take 18 cycles from TRIG to the next TRIG, excluding the mapping stage's IDLE sampling latency.

Reset
REQ-022 On reset=1 the block SHALL go to IDLE at the next edge regardless of state, including mid-vote.
REQ-023 On reset, all of the following SHALL be 0: pufTrigger, busy, done, error, responseOut, stableMask, pufChallenge, the counters, the sample index and the watchdog.
REQ-024 A start coinciding with reset SHALL be ignored.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Stable PUF: model returns 16'hA5C3 every sample, NUM_SAMPLES=15 -> 15 pufTrigger pulses; done with responseOut=16'hA5C3, stableMask=16'hFFFF, error=0.
- Noisy bit: bit0 is 1 in 8 of 15 samples, other bits constant 0 -> responseOut=16'h0001, stableMask=16'hFFFE; with 7 of 15 instead -> responseOut=16'h0000.
- Timeout: the model never asserts pufDone -> done exactly TIMEOUT+2 cycles after TRIG, with error=1, responseOut=0 and stableMask=0.
- Start while busy: a second start with a different challenge mid-vote -> pufChallenge unchanged and only one done.
- Reset mid-vote: reset during WAIT of sample 5 -> all outputs 0 the next cycle; a fresh start then yields a full 15-sample vote.
- Stray pufDone in IDLE and TRIG -> counters unaffected, and the final result equals the stable-PUF case.
